// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared owner encodings and read tag type for the dmem port arbiter
package dmem_arb_pkg;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - request/grant/read-valid bundle for one memory requester
interface dmem_port_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;

  modport master (output req, we, addr, wdata, input gnt, rvalid);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid);
endinterface

// File: rtl/dmem_rd_tag_pipe.sv
// rtl/dmem_rd_tag_pipe.sv - RD_LAT-deep shift register carrying {valid, owner} per memory access
module dmem_rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);
  rd_tag_t [RD_LAT-1:0] stages;

  // Shift the tag along once per cycle; reset drops every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[RD_LAT-1];
endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares single-port data memory between CPU MEM stage and debug port
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 64,
  parameter int DW       = 64,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt,
  dmem_port_arbiter_if.slave cpu,
  dmem_port_arbiter_if.slave dbg,
  output logic               cpu_stall,
  output logic [DW-1:0]      rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          cpu_gnt;
  logic          dbg_gnt;
  rd_tag_t       tag_in;
  rd_tag_t       tag_out;

  assign starved = (starve_cnt == CW'(MAX_WAIT));

  // Halt hands memory to dbg; a starved dbg preempts cpu once; otherwise cpu has priority.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n) begin
      if (halt) begin
        dbg_gnt = dbg.req;
      end else if (starved && dbg.req) begin
        dbg_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu.req;
        dbg_gnt = dbg.req & ~cpu.req;
      end
    end
  end

  assign cpu.gnt   = cpu_gnt;
  assign dbg.gnt   = dbg_gnt;
  assign cpu_stall = cpu.req & ~cpu_gnt;

  // Steer the granted requester's fields onto the memory bus; idle bus is all zero.
  always_comb begin
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_we    = dbg.we;
      mem_addr  = dbg.addr;
      mem_wdata = dbg.wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu.we;
      mem_addr  = cpu.addr;
      mem_wdata = cpu.wdata;
    end
  end

  // Count consecutive cycles dbg loses to cpu; saturates so the forced grant stays armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (dbg_gnt || !dbg.req) begin
      starve_cnt <= '0;
    end else if (!halt && !starved) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign tag_in.valid = mem_en & ~mem_we;
  assign tag_in.owner = dbg_gnt ? OWNER_DBG : OWNER_CPU;

  dmem_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign cpu.rvalid = tag_out.valid && (tag_out.owner == OWNER_CPU);
  assign dbg.rvalid = tag_out.valid && (tag_out.owner == OWNER_DBG);
  assign rdata      = mem_rdata;
endmodule
